fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the 32-bit 2:1/3:1 operand muxes in the pipelined MIPS datapath: produces the select lines those muxes consume, plus the load-use stall.
- Keeps its own shadow pipeline of register-destination info (EX, MEM, WB records), advanced in lockstep with the datapath pipeline registers.
- Sits beside the ID/EX boundary.
- Drives the EX operand-A/B forwarding muxes, the PC/IF-ID hold enables and the ID/EX bubble insert.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, branch)
- id_dst  in  REG_W  destination register of the ID instruction (after RegDst select)
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  taken branch/jump: the ID instruction is wrong-path
- fwd_a_sel  out  2  EX operand-A mux select
- fwd_b_sel  out  2  EX operand-B mux select
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- stall_count  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Shadow records:
  - EX = {rs, rt, uses_rt, dst, rw, mr}
  - MEM = {dst, rw, mr}
  - WB = {dst, rw}
- Bubble: rw = 0, mr = 0, all register fields 0.
- Reset (async, immediate): all records become bubbles; fwd_a_sel = 00, fwd_b_sel = 00, stall = 0, stall_count = 0.
- Each rising edge, with reset low:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble if (flush | stall); otherwise EX <= the current ID inputs.
- The records never hold; the datapath stalls only upstream of ID/EX.
- stall (combinational from the EX record and the ID inputs):
  - stall = ~flush & EX.mr & EX.rw & (EX.dst != 0) & ((EX.dst == id_rs) | (id_uses_rt & EX.dst == id_rt)).
  - Lasts exactly 1 cycle per load-use pair: on the next edge the load moves to MEM and a bubble enters EX.
  - flush masks stall.
- fwd_a_sel (combinational from the registered records; applies to the instruction in EX):
  - 01 if MEM.rw & MEM.dst != 0 & MEM.dst == EX.rs (forward the EX/MEM ALU result).
  - else 10 if WB.rw & WB.dst != 0 & WB.dst == EX.rs (forward the write-back value).
  - else 00 (register-file value).
- fwd_b_sel: same rule using EX.rt. It is forced to 00 when EX.uses_rt = 0.
- Priority: MEM beats WB, so the youngest producer wins. Code 11 is never driven.
- Register $0 is never forwarded and never causes a stall.
- A load in MEM matching the EX source cannot occur, because the stall prevents it. If it does occur, the MEM rule still applies as written; no extra detection is required.
- stall_count increments on every edge where stall = 1. It holds at 2^CNT_W - 1.
- Reset asserted mid-stall: stall drops immediately with the records; no pending stall survives reset.
- Simultaneous flush and stall condition: flush wins. stall = 0, EX <= bubble, and the counter does not increment.

Test Plan:
- Reset, then present ALU producer id_dst = 8, rw = 1, followed next cycle by a consumer with id_rs = 8 -> in the consumer's EX cycle fwd_a_sel = 01; one cycle later a second consumer with rs = 8 sees fwd_a_sel = 10.
- Producers to $8 in both MEM and WB, with the EX instruction having rs = rt = 8, uses_rt = 1 -> fwd_a_sel = 01, fwd_b_sel = 01 (MEM priority).
- Load with dst = 9, mr = 1, followed by a consumer with rt = 9, uses_rt = 1 -> stall = 1 for exactly one cycle, stall_count = 1; after the bubble, fwd_b_sel = 10 in the consumer's EX cycle.
- Same load-use pair with flush = 1 in the stall cycle -> stall = 0, stall_count unchanged, EX holds a bubble on the next cycle, fwd selects = 00.
- Producer writing $0 (dst = 0, rw = 1), consumer with rs = 0 -> fwd_a_sel = 00, stall = 0; consumer with uses_rt = 0 and a matching rt -> fwd_b_sel = 00.
- Assert reset asynchronously mid-cycle while stall = 1 -> stall, selects and stall_count go to 0 before the next edge. With CNT_W = 4 and 20 forced stall cycles -> stall_count = 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// Groups the ID-stage register info and the forwarding/stall controls of fwd_hazard_ctrl.
// master: the decode/datapath side (drives ID fields and flush, consumes selects and stall).
// slave:  the hazard controller (consumes ID fields and flush, drives selects, stall and counter).
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall generator for the EX operand muxes of a 5-stage MIPS pipe.
// Latency: selects and stall are combinational; shadow EX/MEM/WB records advance every edge.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX for one cycle per load-use pair; flush masks it.
// Ports: clk, reset (async, active-high); bus (slave modport) carries ID fields, flush,
//        fwd_a_sel/fwd_b_sel (00 regfile, 01 EX/MEM, 10 WB), stall and saturating stall_count.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    fwd_hazard_ctrl_if.slave   bus
);

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rt;
        logic [REG_W-1:0] dst;
        logic             rw;
        logic             mr;
    } ex_rec_t;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             rw;
        logic             mr;
    } mem_rec_t;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             rw;
    } wb_rec_t;

    ex_rec_t          ex_q,  ex_d;
    mem_rec_t         mem_q, mem_d;
    wb_rec_t          wb_q,  wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;

    always_comb begin
        stall         = 1'b0;
        ex_d          = '0;
        mem_d         = '0;
        wb_d          = '0;
        stall_count_d = stall_count_q;
        fwd_a_sel     = 2'b00;
        fwd_b_sel     = 2'b00;

        // Load in EX whose result an ID source needs: the value only exists after MEM.
        stall = ~bus.flush & ex_q.mr & ex_q.rw & (ex_q.dst != '0) &
                ((ex_q.dst == bus.id_rs) | (bus.id_uses_rt & (ex_q.dst == bus.id_rt)));

        // Records always advance; a stalled or wrong-path ID instruction becomes a bubble.
        if (!(bus.flush | stall)) begin
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.uses_rt = bus.id_uses_rt;
            ex_d.dst     = bus.id_dst;
            ex_d.rw      = bus.id_reg_write;
            ex_d.mr      = bus.id_mem_read;
        end
        mem_d.dst = ex_q.dst;
        mem_d.rw  = ex_q.rw;
        mem_d.mr  = ex_q.mr;
        wb_d.dst  = mem_q.dst;
        wb_d.rw   = mem_q.rw;

        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end

        // MEM checked first so the youngest producer wins.
        if (mem_q.rw && (mem_q.dst != '0) && (mem_q.dst == ex_q.rs)) begin
            fwd_a_sel = 2'b01;
        end else if (wb_q.rw && (wb_q.dst != '0) && (wb_q.dst == ex_q.rs)) begin
            fwd_a_sel = 2'b10;
        end

        if (ex_q.uses_rt) begin
            if (mem_q.rw && (mem_q.dst != '0) && (mem_q.dst == ex_q.rt)) begin
                fwd_b_sel = 2'b01;
            end else if (wb_q.rw && (wb_q.dst != '0) && (wb_q.dst == ex_q.rt)) begin
                fwd_b_sel = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_a_sel   = fwd_a_sel;
    assign bus.fwd_b_sel   = fwd_b_sel;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a default instance (CNT_W=16) and a CNT_W=4 instance
// share identical stimulus so counter saturation can be checked alongside the main behaviour.
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) io   ();
    fwd_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  io_s ();

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (io.slave)
    );

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (io_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rs, rt, uses_rt, dst, reg_write, mem_read, flush
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic [4:0] dst, input logic rw, input logic mr, input logic fl);
        io.id_rs = rs;   io.id_rt = rt;   io.id_uses_rt = ut;
        io.id_dst = dst; io.id_reg_write = rw; io.id_mem_read = mr; io.flush = fl;
        io_s.id_rs = rs;   io_s.id_rt = rt;   io_s.id_uses_rt = ut;
        io_s.id_dst = dst; io_s.id_reg_write = rw; io_s.id_mem_read = mr; io_s.flush = fl;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst_a",   32'(io.fwd_a_sel),   0);
        check("rst_b",   32'(io.fwd_b_sel),   0);
        check("rst_st",  32'(io.stall),       0);
        check("rst_cnt", 32'(io.stall_count), 0);
        #4;
        reset = 1'b0;

        // ALU producer to $8 then two consumers of $8
        drive(0, 0, 0, 8, 1, 0, 0);
        tick(); drive(8, 0, 0, 10, 1, 0, 0);
        tick(); drive(8, 0, 0, 11, 1, 0, 0); #1;
        check("alu_mem_a", 32'(io.fwd_a_sel), 32'h1);
        check("alu_stall", 32'(io.stall),     0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("alu_wb_a", 32'(io.fwd_a_sel), 32'h2);
        check("alu_wb_b", 32'(io.fwd_b_sel), 0);

        // $8 producers in both WB and MEM: MEM wins on both operands
        tick(); drive(0, 0, 0, 8, 1, 0, 0);
        tick(); drive(0, 0, 0, 8, 1, 0, 0);
        tick(); drive(8, 8, 1, 12, 1, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("prio_a", 32'(io.fwd_a_sel), 32'h1);
        check("prio_b", 32'(io.fwd_b_sel), 32'h1);

        // Load $9 then consumer using rt=$9
        tick(); drive(2, 0, 0, 9, 1, 1, 0);
        tick(); drive(3, 9, 1, 13, 1, 0, 0); #1;
        check("lu_stall",  32'(io.stall),       1);
        check("lu_cnt0",   32'(io.stall_count), 0);
        tick(); #1;
        check("lu_stall_1cyc", 32'(io.stall),       0);
        check("lu_cnt1",       32'(io.stall_count), 1);
        check("lu_bubble_b",   32'(io.fwd_b_sel),   0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("lu_wb_b", 32'(io.fwd_b_sel), 32'h2);
        check("lu_wb_a", 32'(io.fwd_a_sel), 0);

        // Same pair with flush in the would-be stall cycle
        tick(); drive(2, 0, 0, 9, 1, 1, 0);
        tick(); drive(3, 9, 1, 13, 1, 0, 1); #1;
        check("fl_stall", 32'(io.stall), 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("fl_cnt",    32'(io.stall_count), 1);
        check("fl_bub_a",  32'(io.fwd_a_sel),   0);
        check("fl_bub_b",  32'(io.fwd_b_sel),   0);

        // $0 is never forwarded nor stalls
        tick(); drive(0, 0, 0, 0, 1, 1, 0);
        tick(); drive(0, 0, 1, 14, 1, 0, 0); #1;
        check("r0_stall", 32'(io.stall), 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("r0_a", 32'(io.fwd_a_sel), 0);
        check("r0_b", 32'(io.fwd_b_sel), 0);

        // rt matches a producer but is not read
        tick(); drive(0, 0, 0, 7, 1, 0, 0);
        tick(); drive(1, 7, 0, 15, 1, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("nort_b", 32'(io.fwd_b_sel), 0);
        check("nort_a", 32'(io.fwd_a_sel), 0);

        // Async reset while stalled, with a live forward select
        tick(); drive(0, 0, 0, 2, 1, 0, 0);
        tick(); drive(2, 0, 0, 9, 1, 1, 0);
        tick(); drive(9, 0, 0, 16, 1, 0, 0); #1;
        check("ar_pre_stall", 32'(io.stall),       1);
        check("ar_pre_a",     32'(io.fwd_a_sel),   32'h1);
        check("ar_pre_cnt",   32'(io.stall_count), 1);
        #1; reset = 1'b1; #1;
        check("ar_stall", 32'(io.stall),         0);
        check("ar_a",     32'(io.fwd_a_sel),     0);
        check("ar_cnt",   32'(io.stall_count),   0);
        check("ar_scnt",  32'(io_s.stall_count), 0);

        // Self-dependent load held in ID stalls every other cycle: 20 stalls in 40 edges
        #2; reset = 1'b0;
        drive(9, 0, 0, 9, 1, 1, 0);
        tick(); #1;
        check("sat_stall", 32'(io_s.stall), 1);
        repeat (19) tick();
        #1;
        check("sat_cnt10",  32'(io_s.stall_count), 10);
        repeat (20) tick();
        #1;
        check("sat_main20", 32'(io.stall_count),   20);
        check("sat_cnt15",  32'(io_s.stall_count), 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
